gshare_bht: RTL and testbench



---
 rtl/gshare_bht_pkg.sv | 38 +++
 rtl/gshare_bht_if.sv | 34 +++
 rtl/gshare_bht_flush_sweep.sv | 50 +++++
 rtl/gshare_bht.sv | 161 ++++++++++++++++
 tb/tb_gshare_bht.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gshare_bht_pkg.sv
// Shared types and helpers for the gshare branch history table.
// Entry layout, weakly-taken init value, saturating counter update.
package gshare_bht_pkg;

  localparam int unsigned CTR_W_MAX = 4;

  typedef struct packed {
    logic                 valid;
    logic [CTR_W_MAX-1:0] ctr;
  } bht_entry_t;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } sweep_state_e;

  function automatic bht_entry_t weak_taken_entry(input int unsigned ctr_bits);
    bht_entry_t e;
    e.valid = 1'b0;
    e.ctr   = CTR_W_MAX'(1) << (ctr_bits - 1);
    return e;
  endfunction

  // Counter only occupies the low ctr_bits; the upper bits stay zero.
  function automatic logic [CTR_W_MAX-1:0] sat_ctr_update(
    input logic [CTR_W_MAX-1:0] ctr,
    input logic                 taken,
    input int unsigned          ctr_bits
  );
    logic [CTR_W_MAX-1:0] max_ctr;
    max_ctr = (CTR_W_MAX'(1) << ctr_bits) - CTR_W_MAX'(1);
    if (taken) begin
      return (ctr == max_ctr) ? ctr : ctr + CTR_W_MAX'(1);
    end
    return (ctr == '0) ? ctr : ctr - CTR_W_MAX'(1);
  endfunction

endpackage

// File: rtl/gshare_bht_if.sv
// Frontend/execute bundle of the gshare BHT: fetch lookup, speculative
// history shift and resolved-branch update.
interface gshare_bht_if #(
  parameter int unsigned VLEN            = 64,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned GHR_BITS        = 8
);
  logic                       flush_bp_i;
  logic                       debug_mode_i;
  logic [VLEN-1:0]            vpc_i;
  logic [GHR_BITS-1:0]        ghr_o;
  logic [INSTR_PER_FETCH-1:0] pred_valid_o;
  logic [INSTR_PER_FETCH-1:0] pred_taken_o;
  logic                       ready_o;
  logic                       spec_shift_i;
  logic                       spec_taken_i;
  logic                       upd_valid_i;
  logic [VLEN-1:0]            upd_pc_i;
  logic                       upd_taken_i;
  logic [GHR_BITS-1:0]        upd_ghr_i;
  logic                       upd_mispredict_i;

  modport slave (
    input  flush_bp_i, debug_mode_i, vpc_i, spec_shift_i, spec_taken_i,
           upd_valid_i, upd_pc_i, upd_taken_i, upd_ghr_i, upd_mispredict_i,
    output ghr_o, pred_valid_o, pred_taken_o, ready_o
  );

  modport master (
    output flush_bp_i, debug_mode_i, vpc_i, spec_shift_i, spec_taken_i,
           upd_valid_i, upd_pc_i, upd_taken_i, upd_ghr_i, upd_mispredict_i,
    input  ghr_o, pred_valid_o, pred_taken_o, ready_o
  );
endinterface

// File: rtl/gshare_bht_flush_sweep.sv
// Row-by-row invalidation sweep: SWEEP after reset or flush, IDLE once
// the last row has been written. A flush mid-sweep restarts at row 0.
module bht_flush_sweep
  import gshare_bht_pkg::*;
#(
  parameter int unsigned NR_ROWS  = 512,
  parameter int unsigned ROW_BITS = $clog2(NR_ROWS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  output logic                sweep_active_o,
  output logic [ROW_BITS-1:0] sweep_row_o
);

  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(NR_ROWS - 1);

  sweep_state_e        state_reg, state_next;
  logic [ROW_BITS-1:0] row_reg, row_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= SWEEP;
      row_reg   <= '0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    if (flush_i) begin
      state_next = SWEEP;
      row_next   = '0;
    end else if (state_reg == SWEEP) begin
      if (row_reg == LAST_ROW) begin
        state_next = IDLE;
        row_next   = '0;
      end else begin
        row_next = row_reg + 1'b1;
      end
    end
  end

  assign sweep_active_o = (state_reg == SWEEP);
  assign sweep_row_o    = row_reg;

endmodule

// File: rtl/gshare_bht.sv
// Gshare branch history table: per-slot direction prediction, registered
// read-modify-write update with bypass. CVA6_BHT_GSHARE_EN enables history hashing.
module gshare_bht
  import gshare_bht_pkg::*;
#(
  parameter int unsigned VLEN            = 64,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned NR_ENTRIES      = 1024,
  parameter int unsigned CTR_BITS        = 2,
  parameter int unsigned GHR_BITS        = 8,
  parameter bit          RVC             = 1'b1
) (
  input logic         clk_i,
  input logic         rst_i,
  gshare_bht_if.slave bus
);

  localparam int unsigned NR_ROWS       = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned ROW_BITS      = $clog2(NR_ROWS);
  localparam int unsigned ROW_ADDR_BITS = $clog2(INSTR_PER_FETCH);
  localparam int unsigned COL_W         = (ROW_ADDR_BITS > 0) ? ROW_ADDR_BITS : 1;
  localparam int unsigned OFFSET        = RVC ? 1 : 2;
  localparam int unsigned ROW_LSB       = ROW_ADDR_BITS + OFFSET;
  localparam bht_entry_t  INIT_ENTRY    = weak_taken_entry(CTR_BITS);

  logic                       sweep_active;
  logic [ROW_BITS-1:0]        sweep_row;
  logic [ROW_BITS-1:0]        pred_hash, upd_hash;
  logic [ROW_BITS-1:0]        pred_row, upd_row;
  logic [COL_W-1:0]           upd_col;
  logic [INSTR_PER_FETCH-1:0] pred_valid, pred_taken;

  bht_flush_sweep #(
    .NR_ROWS  (NR_ROWS),
    .ROW_BITS (ROW_BITS)
  ) i_sweep (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (bus.flush_bp_i),
    .sweep_active_o (sweep_active),
    .sweep_row_o    (sweep_row)
  );

`ifdef CVA6_BHT_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_reg, ghr_next;

  // Repair from a mispredicted branch overrides a same-cycle speculative shift.
  always_comb begin
    ghr_next = ghr_reg;
    if (bus.flush_bp_i) begin
      ghr_next = '0;
    end else if (!sweep_active && !bus.debug_mode_i) begin
      if (bus.upd_valid_i && bus.upd_mispredict_i) begin
        ghr_next = GHR_BITS'({bus.upd_ghr_i, bus.upd_taken_i});
      end else if (bus.spec_shift_i) begin
        ghr_next = GHR_BITS'({ghr_reg, bus.spec_taken_i});
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ghr_reg <= '0;
    end else begin
      ghr_reg <= ghr_next;
    end
  end

  assign bus.ghr_o = ghr_reg;
  assign pred_hash = ROW_BITS'(ghr_reg);
  assign upd_hash  = ROW_BITS'(bus.upd_ghr_i);
`else
  logic unused_gshare;
  assign unused_gshare = ^{bus.spec_shift_i, bus.spec_taken_i, bus.upd_ghr_i,
                           bus.upd_mispredict_i};
  assign bus.ghr_o = '0;
  assign pred_hash = '0;
  assign upd_hash  = '0;
`endif

  assign pred_row = bus.vpc_i[ROW_LSB +: ROW_BITS] ^ pred_hash;
  assign upd_row  = bus.upd_pc_i[ROW_LSB +: ROW_BITS] ^ upd_hash;

  if (RVC && (ROW_ADDR_BITS > 0)) begin : g_upd_col
    assign upd_col = bus.upd_pc_i[OFFSET +: ROW_ADDR_BITS];
  end else begin : g_upd_col_zero
    assign upd_col = '0;
  end

  logic unused_pc;
  assign unused_pc = ^{bus.vpc_i, bus.upd_pc_i};

  // Stage 1 holds the physical target, so later history changes cannot redirect it.
  logic                s1_valid_reg, s1_valid_next;
  logic [ROW_BITS-1:0] s1_row_reg;
  logic [COL_W-1:0]    s1_col_reg;
  logic                s1_taken_reg;
  logic                s1_we;
  bht_entry_t          s1_old, s1_new;
  bht_entry_t          upd_rd [INSTR_PER_FETCH];

  assign s1_valid_next = bus.upd_valid_i && !bus.debug_mode_i && !sweep_active
                         && !bus.flush_bp_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= s1_valid_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (s1_valid_next) begin
      s1_row_reg   <= upd_row;
      s1_col_reg   <= upd_col;
      s1_taken_reg <= bus.upd_taken_i;
    end
  end

  assign s1_old     = upd_rd[s1_col_reg];
  assign s1_new.valid = 1'b1;
  assign s1_new.ctr   = sat_ctr_update(s1_old.ctr, s1_taken_reg, CTR_BITS);
  assign s1_we      = s1_valid_reg && !sweep_active && !bus.flush_bp_i && !rst_i;

  logic unused_s1;
  assign unused_s1 = s1_old.valid;

  for (genvar gi = 0; gi < INSTR_PER_FETCH; gi++) begin : g_col
    bht_entry_t          col_mem [NR_ROWS];
    logic                we;
    logic [ROW_BITS-1:0] waddr;
    bht_entry_t          wdata;
    logic                hit;
    bht_entry_t          slot_entry;
    logic                unused_slot;

    assign we    = sweep_active || (s1_we && (s1_col_reg == COL_W'(gi)));
    assign waddr = sweep_active ? sweep_row : s1_row_reg;
    assign wdata = sweep_active ? INIT_ENTRY : s1_new;

    always_ff @(posedge clk_i) begin
      if (we) begin
        col_mem[waddr] <= wdata;
      end
    end

    assign upd_rd[gi] = col_mem[s1_row_reg];

    assign hit        = s1_we && (s1_row_reg == pred_row) && (s1_col_reg == COL_W'(gi));
    assign slot_entry = hit ? s1_new : col_mem[pred_row];
    assign pred_valid[gi] = !sweep_active && slot_entry.valid;
    assign pred_taken[gi] = !sweep_active && slot_entry.ctr[CTR_BITS-1];
    assign unused_slot    = ^slot_entry;
  end

  assign bus.pred_valid_o = pred_valid;
  assign bus.pred_taken_o = pred_taken;
  assign bus.ready_o      = !sweep_active;

endmodule

// File: tb/tb_gshare_bht.sv
// Bench for gshare_bht: vector table, directed corner sequences and random
// traffic against a table/history model indexed by plain arithmetic.
module tb_gshare_bht;

  localparam int VLEN       = 64;
  localparam int IPF        = 2;
  localparam int NR_ENTRIES = 64;
  localparam int CTR_BITS   = 2;
  localparam int GHR_BITS   = 4;
  localparam int NR_ROWS    = NR_ENTRIES / IPF;
`ifdef CVA6_BHT_GSHARE_EN
  localparam bit GSHARE = 1'b1;
`else
  localparam bit GSHARE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gshare_bht_if #(.VLEN(VLEN), .INSTR_PER_FETCH(IPF), .GHR_BITS(GHR_BITS)) bus ();

  gshare_bht #(
    .VLEN(VLEN), .INSTR_PER_FETCH(IPF), .NR_ENTRIES(NR_ENTRIES),
    .CTR_BITS(CTR_BITS), .GHR_BITS(GHR_BITS), .RVC(1'b1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic       upd_v;
    logic       upd_t;
    logic [1:0] exp_v;
    logic [1:0] exp_t;
  } vec_t;

  vec_t vecs [12];
  int   total = 0;
  int   bad   = 0;
  int   m_ctr [NR_ROWS][IPF];
  bit   m_val [NR_ROWS][IPF];
  int   m_ghr;
  int   m_busy;
  bit   chk_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int m_row(input logic [63:0] pc, input int g);
    return int'((pc >> 2) % 64'd32) ^ g;
  endfunction

  function automatic int m_col(input logic [63:0] pc);
    return int'((pc >> 1) % 64'd2);
  endfunction

  task automatic model_flush();
    for (int r = 0; r < NR_ROWS; r++) begin
      for (int c = 0; c < IPF; c++) begin
        m_val[r][c] = 1'b0;
        m_ctr[r][c] = 2;
      end
    end
    m_ghr  = 0;
    m_busy = NR_ROWS;
  endtask

  task automatic idle_inputs();
    bus.flush_bp_i       = 1'b0;
    bus.debug_mode_i     = 1'b0;
    bus.vpc_i            = '0;
    bus.spec_shift_i     = 1'b0;
    bus.spec_taken_i     = 1'b0;
    bus.upd_valid_i      = 1'b0;
    bus.upd_pc_i         = '0;
    bus.upd_taken_i      = 1'b0;
    bus.upd_ghr_i        = '0;
    bus.upd_mispredict_i = 1'b0;
  endtask

  task automatic settle_and_check();
    logic [1:0] ev, et;
    int r;
    #1;
    if (chk_en) begin
      check("ready", bus.ready_o, m_busy == 0);
      check("ghr", bus.ghr_o, GSHARE ? m_ghr : 0);
      ev = '0;
      et = '0;
      if (m_busy == 0) begin
        r = m_row(bus.vpc_i, GSHARE ? m_ghr : 0);
        for (int i = 0; i < IPF; i++) begin
          ev[i] = m_val[r][i];
          et[i] = (m_ctr[r][i] >= 2);
        end
      end
      if (!(bus.flush_bp_i || rst)) begin
        check("pred_valid", bus.pred_valid_o, ev);
        check("pred_taken", bus.pred_taken_o, et);
      end
    end
  endtask

  task automatic tick();
    bit fl, dbg, uv, ut, mp, ss, st;
    int busy_before, r, c, ug;
    logic [63:0] upc;
    busy_before = m_busy;
    fl  = rst || bus.flush_bp_i;
    dbg = bus.debug_mode_i;
    uv  = bus.upd_valid_i;
    ut  = bus.upd_taken_i;
    mp  = bus.upd_mispredict_i;
    ss  = bus.spec_shift_i;
    st  = bus.spec_taken_i;
    ug  = int'(bus.upd_ghr_i);
    upc = bus.upd_pc_i;
    @(posedge clk);
    #1;
    if (!fl && busy_before == 0 && !dbg) begin
      if (uv) begin
        r = m_row(upc, GSHARE ? ug : 0);
        c = m_col(upc);
        m_ctr[r][c] = ut ? ((m_ctr[r][c] < 3) ? m_ctr[r][c] + 1 : 3)
                         : ((m_ctr[r][c] > 0) ? m_ctr[r][c] - 1 : 0);
        m_val[r][c] = 1'b1;
        $display("upd pc=%0h row=%0d col=%0d taken=%0b ctr=%0d", upc, r, c, ut, m_ctr[r][c]);
      end
      if (uv && mp) m_ghr = (ug * 2 + int'(ut)) % 16;
      else if (ss)  m_ghr = (m_ghr * 2 + int'(st)) % 16;
    end
    if (fl) model_flush();
    else if (m_busy > 0) m_busy--;
  endtask

  task automatic cycle();
    settle_and_check();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Counter chain at pc 0x80 (row 0, slot 0); slot 1 stays untouched.
    vecs[0]  = '{1'b1, 1'b1, 2'b00, 2'b11};
    vecs[1]  = '{1'b1, 1'b1, 2'b01, 2'b11};
    vecs[2]  = '{1'b1, 1'b1, 2'b01, 2'b11};
    vecs[3]  = '{1'b1, 1'b1, 2'b01, 2'b11};
    vecs[4]  = '{1'b1, 1'b0, 2'b01, 2'b11};
    vecs[5]  = '{1'b1, 1'b0, 2'b01, 2'b11};
    vecs[6]  = '{1'b1, 1'b0, 2'b01, 2'b10};
    vecs[7]  = '{1'b0, 1'b0, 2'b01, 2'b10};
    vecs[8]  = '{1'b1, 1'b1, 2'b01, 2'b10};
    vecs[9]  = '{1'b0, 1'b0, 2'b01, 2'b10};
    vecs[10] = '{1'b1, 1'b1, 2'b01, 2'b10};
    vecs[11] = '{1'b0, 1'b0, 2'b01, 2'b11};

    idle_inputs();
    rst    = 1'b1;
    chk_en = 1'b0;
    model_flush();
    cycle();
    rst    = 1'b0;
    chk_en = 1'b1;

    check("rst_ready", bus.ready_o, 0);
    check("rst_ghr", bus.ghr_o, 0);
    check("rst_pvalid", bus.pred_valid_o, 0);
    check("rst_ptaken", bus.pred_taken_o, 0);
    n = 0;
    while (bus.ready_o !== 1'b1 && n < 200) begin
      cycle();
      n++;
    end
    check("sweep_len", n, 32);
    $display("reset sweep cycles=%0d", n);

    bus.vpc_i = 64'h80;
    settle_and_check();
    check("init_valid", bus.pred_valid_o, 2'b00);
    check("init_taken", bus.pred_taken_o, 2'b11);
    tick();

    for (int i = 0; i < 12; i++) begin
      bus.vpc_i       = 64'h80;
      bus.upd_pc_i    = 64'h80;
      bus.upd_valid_i = vecs[i].upd_v;
      bus.upd_taken_i = vecs[i].upd_t;
      settle_and_check();
      check($sformatf("vec%0d_valid", i), bus.pred_valid_o, vecs[i].exp_v);
      check($sformatf("vec%0d_taken", i), bus.pred_taken_o, vecs[i].exp_t);
      $display("vec %0d upd=%0b taken=%0b pv=%b pt=%b", i, vecs[i].upd_v, vecs[i].upd_t,
               bus.pred_valid_o, bus.pred_taken_o);
      tick();
    end
    idle_inputs();

    bus.spec_shift_i = 1'b1;
    bus.spec_taken_i = 1'b1;
    repeat (3) cycle();
    idle_inputs();
    check("ghr_shift3", bus.ghr_o, GSHARE ? 7 : 0);
    bus.spec_shift_i     = 1'b1;
    bus.spec_taken_i     = 1'b1;
    bus.upd_valid_i      = 1'b1;
    bus.upd_mispredict_i = 1'b1;
    bus.upd_ghr_i        = 4'b0001;
    bus.upd_taken_i      = 1'b0;
    bus.upd_pc_i         = 64'h40;
    cycle();
    idle_inputs();
    check("ghr_repair", bus.ghr_o, GSHARE ? 2 : 0);
    $display("ghr after repair=%0h", bus.ghr_o);

    bus.flush_bp_i = 1'b1;
    cycle();
    bus.flush_bp_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.upd_valid_i = (k == 3);
      bus.upd_pc_i    = 64'h80;
      bus.upd_taken_i = 1'b1;
      cycle();
    end
    bus.upd_valid_i = 1'b0;
    bus.flush_bp_i  = 1'b1;
    cycle();
    bus.flush_bp_i = 1'b0;
    n = 0;
    while (bus.ready_o !== 1'b1 && n < 200) begin
      bus.upd_valid_i = (n == 5);
      cycle();
      n++;
    end
    idle_inputs();
    check("flush_restart_len", n, 32);
    bus.vpc_i = 64'h80;
    settle_and_check();
    check("flush_trace_valid", bus.pred_valid_o, 2'b00);
    check("flush_trace_taken", bus.pred_taken_o, 2'b11);
    $display("flush restart cycles=%0d", n);
    tick();

    bus.upd_valid_i = 1'b1;
    bus.upd_pc_i    = 64'h84;
    bus.upd_taken_i = 1'b0;
    cycle();
    bus.debug_mode_i     = 1'b1;
    bus.upd_taken_i      = 1'b1;
    bus.upd_mispredict_i = 1'b1;
    bus.upd_ghr_i        = 4'b0101;
    bus.spec_shift_i     = 1'b1;
    bus.spec_taken_i     = 1'b1;
    repeat (3) cycle();
    idle_inputs();
    bus.vpc_i = 64'h84;
    settle_and_check();
    check("dbg_ghr", bus.ghr_o, 0);
    check("dbg_valid", bus.pred_valid_o, 2'b01);
    check("dbg_taken", bus.pred_taken_o, 2'b10);
    $display("debug pv=%b pt=%b ghr=%0h", bus.pred_valid_o, bus.pred_taken_o, bus.ghr_o);
    tick();

    for (int k = 0; k < 400; k++) begin
      bus.vpc_i            = 64'($urandom_range(0, 63)) << 1;
      bus.upd_pc_i         = 64'($urandom_range(0, 63)) << 1;
      bus.upd_valid_i      = ($urandom_range(0, 9) < 4);
      bus.upd_taken_i      = 1'($urandom_range(0, 1));
      bus.upd_ghr_i        = 4'($urandom_range(0, 15));
      bus.upd_mispredict_i = ($urandom_range(0, 3) == 0);
      bus.spec_shift_i     = ($urandom_range(0, 2) == 0);
      bus.spec_taken_i     = 1'($urandom_range(0, 1));
      bus.debug_mode_i     = ($urandom_range(0, 19) == 0);
      bus.flush_bp_i       = ($urandom_range(0, 99) == 0);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
